pwr_switch_seq: RTL and testbench

Multi-channel power-switch sequencer for switchable power domains. Each channel turns a domain's header switch on or off in response to a request, ordering the retention save/restore, isolation and switch-enable controls and waiting for the switch acknowledge. It sits in the always-on domain next to the power-management logic, one channel per gated domain. It replaces single-signal direct switch drive, which has no sequencing, handshake or inrush control.

---
 rtl/pwr_switch_seq.sv | 153 +++++++++++++++
 tb/tb_pwr_switch_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pwr_switch_seq.sv
// Multi-channel power-switch sequencer: one Moore FSM per gated domain ordering
// save/isolation/switch-enable/restore, with inrush arbitration and ack timeout.
module pwr_switch_seq #(
    parameter int N_CH       = 4,
    parameter int ISO_DLY    = 2,
    parameter int STABLE_DLY = 4,
    parameter int ACK_TMO    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] pwr_req,
    input  logic [N_CH-1:0] sw_ack,
    output logic [N_CH-1:0] sw_en,
    output logic [N_CH-1:0] iso_en,
    output logic [N_CH-1:0] save,
    output logic [N_CH-1:0] restore,
    output logic [N_CH-1:0] pwr_ok,
    output logic [N_CH-1:0] busy,
    output logic [N_CH-1:0] err
);

    localparam int MAX_A   = (ISO_DLY > STABLE_DLY) ? ISO_DLY : STABLE_DLY;
    localparam int MAX_DLY = (MAX_A > ACK_TMO) ? MAX_A : ACK_TMO;
    localparam int CW      = $clog2(MAX_DLY + 1);

    // Counters hold "cycles remaining minus one" so the exit test is a compare to zero.
    localparam logic [CW-1:0] ISO_LD = CW'(ISO_DLY - 1);
    localparam logic [CW-1:0] STB_LD = CW'(STABLE_DLY - 1);
    localparam logic [CW-1:0] TMO_LD = CW'(ACK_TMO - 1);

    typedef enum logic [3:0] {
        S_OFF,
        S_PWR_UP,
        S_SETTLE,
        S_RESTORE,
        S_ON,
        S_SAVE,
        S_ISO,
        S_PWR_DN,
        S_ERR
    } state_e;

    logic [N_CH-1:0] up_busy;
    logic [N_CH-1:0] req_off;
    logic [N_CH-1:0] grant;
    logic            found;

    // Only one domain may be charging at a time; lowest requesting index wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (req_off[i] && !found) begin
                grant[i] = !(|up_busy);
                found    = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            state_e          state_q, state_d;
            logic [CW-1:0]   cnt_q, cnt_d;
            logic [6:0]      out_d;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= S_OFF;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                out_d   = 7'b0100000;
                case (state_q)
                    S_OFF: begin
                        out_d = 7'b0100000;
                        if (grant[gi]) begin
                            state_d = S_PWR_UP;
                            cnt_d   = TMO_LD;
                        end
                    end
                    S_PWR_UP: begin
                        out_d = 7'b1100010;
                        if (sw_ack[gi]) begin
                            state_d = S_SETTLE;
                            cnt_d   = STB_LD;
                        end else if (cnt_q == '0) begin
                            state_d = S_ERR;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        out_d = 7'b1100010;
                        if (cnt_q == '0) state_d = S_RESTORE;
                        else             cnt_d   = cnt_q - 1'b1;
                    end
                    S_RESTORE: begin
                        out_d   = 7'b1101010;
                        state_d = S_ON;
                    end
                    S_ON: begin
                        out_d = 7'b1000100;
                        if (!pwr_req[gi]) state_d = S_SAVE;
                    end
                    S_SAVE: begin
                        out_d   = 7'b1010010;
                        state_d = S_ISO;
                        cnt_d   = ISO_LD;
                    end
                    S_ISO: begin
                        out_d = 7'b1100010;
                        if (cnt_q == '0) begin
                            state_d = S_PWR_DN;
                            cnt_d   = TMO_LD;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    S_PWR_DN: begin
                        out_d = 7'b0100010;
                        if (!sw_ack[gi]) begin
                            state_d = S_OFF;
                        end else if (cnt_q == '0) begin
                            state_d = S_ERR;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    S_ERR: begin
                        out_d = 7'b0100001;
                        if (!pwr_req[gi]) state_d = S_OFF;
                    end
                    default: begin
                        state_d = S_OFF;
                    end
                endcase
            end

            assign up_busy[gi] = (state_q == S_PWR_UP) || (state_q == S_SETTLE);
            assign req_off[gi] = (state_q == S_OFF) && pwr_req[gi];
            assign {sw_en[gi], iso_en[gi], save[gi], restore[gi],
                    pwr_ok[gi], busy[gi], err[gi]} = out_d;
        end
    endgenerate

endmodule

// File: tb/tb_pwr_switch_seq.sv
// Directed bench for pwr_switch_seq: hand-derived per-cycle channel states are
// queued before each clock and compared against the DUT outputs after it.
module tb_pwr_switch_seq;

    localparam int N = 2;

    localparam int T_OFF = 0, T_UP = 1, T_SET = 2, T_RES = 3, T_ON = 4,
                   T_SAV = 5, T_ISO = 6, T_DN = 7, T_ERR = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] pwr_req;
    logic [N-1:0] sw_ack;
    logic [N-1:0] sw_en, iso_en, save, restore, pwr_ok, busy, err;

    logic [N-1:0] ack_d1, ack_d2, stuck;

    string        tag_q[$];
    logic [13:0]  exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    pwr_switch_seq #(
        .N_CH(N), .ISO_DLY(2), .STABLE_DLY(3), .ACK_TMO(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pwr_req(pwr_req), .sw_ack(sw_ack),
        .sw_en(sw_en), .iso_en(iso_en), .save(save), .restore(restore),
        .pwr_ok(pwr_ok), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output tuple {sw_en,iso_en,save,restore,pwr_ok,busy,err} for each state.
    function automatic logic [6:0] st_out(input int s);
        case (s)
            T_OFF:   return 7'b0100000;
            T_UP:    return 7'b1100010;
            T_SET:   return 7'b1100010;
            T_RES:   return 7'b1101010;
            T_ON:    return 7'b1000100;
            T_SAV:   return 7'b1010010;
            T_ISO:   return 7'b1100010;
            T_DN:    return 7'b0100010;
            default: return 7'b0100001;
        endcase
    endfunction

    function automatic logic [13:0] observed();
        logic [13:0] o;
        for (int i = 0; i < N; i++)
            o[i*7 +: 7] = {sw_en[i], iso_en[i], save[i], restore[i],
                           pwr_ok[i], busy[i], err[i]};
        return o;
    endfunction

    task automatic push(input string tag, input int s0, input int s1);
        tag_q.push_back(tag);
        exp_q.push_back({st_out(s1), st_out(s0)});
    endtask

    task automatic check_queue();
        logic [13:0] e;
        logic [13:0] o;
        string       t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            o = observed();
            n_checks++;
            assert (o === e) else begin
                n_fail++;
                $error("FAIL %s: observed=%h expected=%h", t, o, e);
            end
        end
    endtask

    // One clock: advance the 2-cycle ack model, then compare queued expectations.
    task automatic step();
        @(posedge clk);
        #1;
        ack_d2 = ack_d1;
        ack_d1 = sw_en;
        sw_ack = ack_d2 & ~stuck;
        check_queue();
    endtask

    task automatic cyc(input string tag, input int s0, input int s1);
        push(tag, s0, s1);
        step();
        $display("cycle %-10s pwr_req=%b sw_ack=%b sw_en=%b iso_en=%b save=%b restore=%b pwr_ok=%b busy=%b err=%b",
                 tag, pwr_req, sw_ack, sw_en, iso_en, save, restore, pwr_ok, busy, err);
    endtask

    initial begin
        rst_n   = 1'b0;
        pwr_req = '0;
        sw_ack  = '0;
        ack_d1  = '0;
        ack_d2  = '0;
        stuck   = '0;
        repeat (2) @(posedge clk);
        #1;
        push("reset", T_OFF, T_OFF);
        check_queue();
        rst_n = 1'b1;
        cyc("idle", T_OFF, T_OFF);

        // Ch0 power-up
        pwr_req = 2'b01;
        cyc("up0_pu1", T_UP,  T_OFF);
        cyc("up0_pu2", T_UP,  T_OFF);
        cyc("up0_st1", T_SET, T_OFF);
        cyc("up0_st2", T_SET, T_OFF);
        cyc("up0_st3", T_SET, T_OFF);
        cyc("up0_res", T_RES, T_OFF);
        cyc("up0_on",  T_ON,  T_OFF);
        cyc("up0_on2", T_ON,  T_OFF);

        // Ch0 power-down
        pwr_req = 2'b00;
        cyc("dn0_sav", T_SAV, T_OFF);
        cyc("dn0_is1", T_ISO, T_OFF);
        cyc("dn0_is2", T_ISO, T_OFF);
        cyc("dn0_dn1", T_DN,  T_OFF);
        cyc("dn0_dn2", T_DN,  T_OFF);
        cyc("dn0_off", T_OFF, T_OFF);
        cyc("idle2",   T_OFF, T_OFF);

        // Simultaneous request: ch1 waits for ch0's up phase
        pwr_req = 2'b11;
        cyc("arb_1",  T_UP,  T_OFF);
        cyc("arb_2",  T_UP,  T_OFF);
        cyc("arb_3",  T_SET, T_OFF);
        cyc("arb_4",  T_SET, T_OFF);
        cyc("arb_5",  T_SET, T_OFF);
        cyc("arb_6",  T_RES, T_OFF);
        cyc("arb_7",  T_ON,  T_UP);
        cyc("arb_8",  T_ON,  T_UP);
        cyc("arb_9",  T_ON,  T_SET);
        cyc("arb_10", T_ON,  T_SET);
        cyc("arb_11", T_ON,  T_SET);
        cyc("arb_12", T_ON,  T_RES);
        cyc("arb_13", T_ON,  T_ON);

        // Ch1 down, then up with its ack stuck low
        pwr_req = 2'b01;
        cyc("dn1_sav", T_ON, T_SAV);
        cyc("dn1_is1", T_ON, T_ISO);
        cyc("dn1_is2", T_ON, T_ISO);
        cyc("dn1_dn1", T_ON, T_DN);
        cyc("dn1_dn2", T_ON, T_DN);
        cyc("dn1_off", T_ON, T_OFF);
        stuck   = 2'b10;
        sw_ack  = ack_d2 & ~stuck;
        pwr_req = 2'b11;
        for (int i = 0; i < 8; i++) cyc($sformatf("tmo_pu%0d", i), T_ON, T_UP);
        cyc("tmo_err",  T_ON, T_ERR);
        cyc("tmo_hold", T_ON, T_ERR);
        pwr_req = 2'b01;
        cyc("err_clr",  T_ON, T_OFF);
        stuck   = 2'b00;

        // Ch0 down again, then request dropped mid-SETTLE
        pwr_req = 2'b00;
        cyc("dn0b_sav", T_SAV, T_OFF);
        cyc("dn0b_is1", T_ISO, T_OFF);
        cyc("dn0b_is2", T_ISO, T_OFF);
        cyc("dn0b_dn1", T_DN,  T_OFF);
        cyc("dn0b_dn2", T_DN,  T_OFF);
        cyc("dn0b_off", T_OFF, T_OFF);
        pwr_req = 2'b01;
        cyc("tg_pu1", T_UP,  T_OFF);
        cyc("tg_pu2", T_UP,  T_OFF);
        cyc("tg_st1", T_SET, T_OFF);
        pwr_req = 2'b00;
        cyc("tg_st2", T_SET, T_OFF);
        cyc("tg_st3", T_SET, T_OFF);
        cyc("tg_res", T_RES, T_OFF);
        cyc("tg_on",  T_ON,  T_OFF);
        cyc("tg_sav", T_SAV, T_OFF);
        cyc("tg_is1", T_ISO, T_OFF);
        cyc("tg_is2", T_ISO, T_OFF);
        cyc("tg_dn1", T_DN,  T_OFF);
        cyc("tg_dn2", T_DN,  T_OFF);
        cyc("tg_off", T_OFF, T_OFF);

        // Asynchronous reset while in RESTORE
        pwr_req = 2'b01;
        cyc("rr_pu1", T_UP,  T_OFF);
        cyc("rr_pu2", T_UP,  T_OFF);
        cyc("rr_st1", T_SET, T_OFF);
        cyc("rr_st2", T_SET, T_OFF);
        cyc("rr_st3", T_SET, T_OFF);
        cyc("rr_res", T_RES, T_OFF);
        #2;
        pwr_req = 2'b00;
        rst_n   = 1'b0;
        #1;
        push("rr_async", T_OFF, T_OFF);
        check_queue();
        #1;
        rst_n = 1'b1;
        cyc("rr_post1", T_OFF, T_OFF);
        cyc("rr_post2", T_OFF, T_OFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
